// File: rtl/xspi_txn_scheduler.sv
// xSPI transaction scheduler: round-robin arbitration over N_REQ requesters, one
// transaction in flight, CRC/timeout-driven retransmission, one response per request.
module xspi_txn_scheduler #(
   parameter int N_REQ          = 2,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GAP_CYCLES     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_REQ-1:0]      i_req_valid,
   output logic [N_REQ-1:0]      o_req_ready,
   input  logic [8*N_REQ-1:0]    i_req_cmd,
   input  logic [48*N_REQ-1:0]   i_req_addr,
   input  logic [64*N_REQ-1:0]   i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [2:0]            o_rsp_id,
   output logic [63:0]           o_rsp_rdata,
   output logic [1:0]            o_rsp_status,
   output logic [3:0]            o_rsp_attempts,
   output logic                  o_busy,
   output logic                  o_xspi_start,
   output logic [7:0]            o_xspi_command,
   output logic [47:0]           o_xspi_address,
   output logic [63:0]           o_xspi_wr_data,
   input  logic [63:0]           i_xspi_rd_data,
   input  logic                  i_xspi_done,
   input  logic                  i_xspi_ready,
   input  logic [3:0]            i_crc_err_in
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t        r_state, w_state_nx;
   logic [2:0]    r_last, r_id, w_gnt;
   logic          w_found, w_grant, w_done_rise, w_err_now, w_tmo, w_fail, w_retry;
   logic [7:0]    w_cmd, r_cmd;
   logic [47:0]   w_addr, r_addr;
   logic [63:0]   w_wdata, r_wdata, r_cap;
   logic [TW-1:0] r_tmo;
   logic [GW-1:0] r_gap;
   logic [3:0]    r_att;
   logic          r_sticky, r_done_q;
   logic          r_rsp_valid, r_busy, r_start;
   logic [2:0]    r_rsp_id;
   logic [63:0]   r_rsp_rdata;
   logic [1:0]    r_rsp_status;
   logic [3:0]    r_rsp_att;

   // Round-robin winner (first pass above last grant, second pass wraps) and its payload.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = 3'd0;
      w_cmd   = 8'h00;
      w_addr  = 48'h0;
      w_wdata = 64'h0;
      for (int j = 0; j < N_REQ; j++) begin
         w_gnt   = (!w_found && i_req_valid[j] && (3'(j) > r_last)) ? 3'(j) : w_gnt;
         w_found = w_found | (i_req_valid[j] && (3'(j) > r_last));
      end
      for (int j = 0; j < N_REQ; j++) begin
         w_gnt   = (!w_found && i_req_valid[j] && (3'(j) <= r_last)) ? 3'(j) : w_gnt;
         w_found = w_found | (i_req_valid[j] && (3'(j) <= r_last));
      end
      for (int k = 0; k < N_REQ; k++) begin
         w_cmd   = (3'(k) == w_gnt) ? i_req_cmd[8*k +: 8]    : w_cmd;
         w_addr  = (3'(k) == w_gnt) ? i_req_addr[48*k +: 48] : w_addr;
         w_wdata = (3'(k) == w_gnt) ? i_req_wdata[64*k +: 64] : w_wdata;
      end
   end

   // Next-state decode; a done edge in the same cycle as the timeout wins.
   always_comb begin
      w_state_nx  = r_state;
      w_grant     = 1'b0;
      w_fail      = 1'b0;
      w_done_rise = i_xspi_done & ~r_done_q;
      w_err_now   = r_sticky | (|i_crc_err_in);
      w_tmo       = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
      w_retry     = ({1'b0, r_att} <= 5'(MAX_RETRY));
      case (r_state)
         S_IDLE: begin
            if (i_xspi_ready && w_found) begin
               w_grant    = 1'b1;
               w_state_nx = S_ISSUE;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_ISSUE: w_state_nx = S_WAIT;
         S_WAIT: begin
            if (w_done_rise && !w_err_now) begin
               w_state_nx = S_RESP;
            end else if (w_done_rise || w_tmo) begin
               w_fail     = 1'b1;
               w_state_nx = w_retry ? S_GAP : S_RESP;
            end else begin
               w_state_nx = S_WAIT;
            end
         end
         S_GAP: begin
            if ((r_gap == GW'(GAP_CYCLES - 1)) && i_xspi_ready) begin
               w_state_nx = S_ISSUE;
            end else begin
               w_state_nx = S_GAP;
            end
         end
         S_RESP:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Payload capture, attempt/timeout/gap counters and registered response/status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= 3'(N_REQ - 1);
         r_id <= 3'd0;          r_cmd <= 8'h00;        r_addr <= 48'h0;
         r_wdata <= 64'h0;      r_cap <= 64'h0;        r_tmo <= '0;
         r_gap <= '0;           r_att <= 4'd0;         r_sticky <= 1'b0;
         r_done_q <= 1'b0;      r_rsp_valid <= 1'b0;   r_busy <= 1'b0;
         r_start <= 1'b0;       r_rsp_id <= 3'd0;      r_rsp_rdata <= 64'h0;
         r_rsp_status <= 2'b00; r_rsp_att <= 4'd0;
      end else begin
         r_done_q    <= i_xspi_done;
         r_rsp_valid <= (w_state_nx == S_RESP);
         r_busy      <= (w_state_nx != S_IDLE);
         r_start     <= (w_state_nx == S_ISSUE);
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_cmd   <= w_cmd;
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_id    <= w_gnt;
                  r_last  <= w_gnt;
                  r_att   <= 4'd0;
                  r_cap   <= 64'h0;
               end
            end
            S_ISSUE: begin
               r_att    <= (r_att == 4'd15) ? 4'd15 : r_att + 4'd1;
               r_sticky <= 1'b0;
               r_tmo    <= '0;
               r_done_q <= 1'b0;
            end
            S_WAIT: begin
               r_sticky <= w_err_now;
               r_tmo    <= r_tmo + TW'(1);
               r_gap    <= '0;
               if (w_done_rise) begin
                  r_cap <= i_xspi_rd_data;
               end
               if (w_state_nx == S_RESP) begin
                  r_rsp_id     <= r_id;
                  r_rsp_att    <= r_att;
                  r_rsp_rdata  <= w_done_rise ? i_xspi_rd_data : r_cap;
                  r_rsp_status <= !w_fail ? 2'b00 : (w_done_rise ? 2'b01 : 2'b10);
               end
            end
            S_GAP: begin
               r_gap <= (r_gap == GW'(GAP_CYCLES - 1)) ? r_gap : r_gap + GW'(1);
            end
            default: begin
               r_gap <= r_gap;
            end
         endcase
      end
   end

   assign o_req_ready    = (w_grant && !i_rst) ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gnt)
                                               : {N_REQ{1'b0}};
   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_id       = r_rsp_id;
   assign o_rsp_rdata    = r_rsp_rdata;
   assign o_rsp_status   = r_rsp_status;
   assign o_rsp_attempts = r_rsp_att;
   assign o_busy         = r_busy;
   assign o_xspi_start   = r_start;
   assign o_xspi_command = r_cmd;
   assign o_xspi_address = r_addr;
   assign o_xspi_wr_data = r_wdata;

endmodule

// File: tb/tb_xspi_txn_scheduler.sv
// Directed bench for xspi_txn_scheduler: behavioural xSPI responder, response scoreboard,
// start-pulse timing checks against the retry/gap/timeout arithmetic.
module tb_xspi_txn_scheduler;
   localparam int N_REQ = 2, MAX_RETRY = 3, TO = 32, GAP = 4, DLY = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rsp_valid, busy, xspi_start, xspi_done, xspi_ready;
   logic [N_REQ-1:0] req_valid, req_ready;
   logic [8*N_REQ-1:0] req_cmd;
   logic [48*N_REQ-1:0] req_addr;
   logic [64*N_REQ-1:0] req_wdata;
   logic [2:0] rsp_id;
   logic [63:0] rsp_rdata, xspi_wr_data, xspi_rd_data;
   logic [1:0] rsp_status;
   logic [3:0] rsp_attempts, crc_err;
   logic [7:0] xspi_command;
   logic [47:0] xspi_address;
   logic [7:0] p_cmd [N_REQ];
   logic [47:0] p_addr [N_REQ];
   logic [63:0] p_wdata [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_cmd[8*i +: 8]    = p_cmd[i];
         req_addr[48*i +: 48] = p_addr[i];
         req_wdata[64*i +: 64] = p_wdata[i];
      end
   end

   xspi_txn_scheduler #(.N_REQ(N_REQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYCLES(TO),
                        .GAP_CYCLES(GAP)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_cmd(req_cmd), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_rdata(rsp_rdata),
      .o_rsp_status(rsp_status), .o_rsp_attempts(rsp_attempts), .o_busy(busy),
      .o_xspi_start(xspi_start), .o_xspi_command(xspi_command),
      .o_xspi_address(xspi_address), .o_xspi_wr_data(xspi_wr_data),
      .i_xspi_rd_data(xspi_rd_data), .i_xspi_done(xspi_done), .i_xspi_ready(xspi_ready),
      .i_crc_err_in(crc_err));

   typedef struct {logic [2:0] id; logic [1:0] st; logic [3:0] att; logic [63:0] rd;} exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0;
   int n_start = 0, n_grant = 0, n_rsp = 0, gnt_at_rsp = 0;
   int gnt_log[$];
   int cfg_err_atts = 0;
   logic [3:0] cfg_err = 4'h0;
   bit cfg_never_done = 1'b0;
   int done_cyc = -1000;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rd_of(input int id, input int att);
      return {16'hC0DE, 8'(id), 32'h0, 8'(att)};
   endfunction

   task automatic push_exp(input int id, input logic [1:0] st, input int att, input logic [63:0] rd);
      exp_t e;
      e.id = 3'(id); e.st = st; e.att = 4'(att); e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input int target);
      int k = 0;
      while (n_grant < target && k < 400) begin @(negedge clk); k++; end
      check("grant_wait", 128'(n_grant), 128'(target));
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int k = 0;
      while (n_rsp < target && k < budget) begin @(negedge clk); k++; end
      check("rsp_wait", 128'(n_rsp), 128'(target));
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural xSPI pair: done DLY cycles after each start, optional CRC pulse mid-attempt.
   initial begin
      int att_idx = 0, cnt = 0, tid = 0;
      bit active = 1'b0;
      xspi_done = 1'b0; crc_err = 4'h0; xspi_rd_data = 64'h0;
      forever begin
         @(negedge clk);
         xspi_done = 1'b0;
         crc_err = 4'h0;
         for (int i = 0; i < N_REQ; i++)
            if (req_ready[i]) begin att_idx = 0; tid = i; end
         if (xspi_start) begin
            att_idx++; cnt = 0; active = 1'b1;
         end else if (active) begin
            cnt++;
            if (cnt == DLY / 2 && att_idx <= cfg_err_atts) crc_err = cfg_err;
            if (cnt == DLY && !cfg_never_done) begin
               xspi_done = 1'b1; xspi_rd_data = rd_of(tid, att_idx);
               active = 1'b0; done_cyc = cyc;
            end
         end
      end
   end

   // Monitor: grants, start timing/payload, responses against the scoreboard.
   initial begin
      int cur_att = 0, gid = 0, last_gnt_cyc = 0, prev_start = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (|req_ready) begin
            check("grant_only_idle", 128'({busy, $onehot(req_ready)}), 128'(2'b01));
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gid = i;
            gnt_log.push_back(gid);
            n_grant++; last_gnt_cyc = cyc; cur_att = 0;
         end
         if (xspi_start) begin
            n_start++; cur_att++;
            if (cur_att == 1)
               check("grant_to_start", 128'(cyc), 128'(last_gnt_cyc + 1));
            else if (done_cyc > prev_start)
               check("crc_retry_spacing", 128'(cyc), 128'(done_cyc + GAP + 1));
            else
               check("tmo_retry_spacing", 128'(cyc), 128'(prev_start + TO + GAP + 1));
            check("start_payload", {8'h00, xspi_command, xspi_address, xspi_wr_data},
                  {8'h00, p_cmd[gid], p_addr[gid], p_wdata[gid]});
            prev_start = cyc;
         end
         if (rsp_valid) begin
            n_rsp++; gnt_at_rsp = n_grant;
            if (sb.size() == 0) begin
               check("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
               e = sb.pop_front();
               check("rsp_id", 128'(rsp_id), 128'(e.id));
               check("rsp_status", 128'(rsp_status), 128'(e.st));
               check("rsp_attempts", 128'(rsp_attempts), 128'(e.att));
               check("rsp_rdata", 128'(rsp_rdata), 128'(e.rd));
               if (e.st != 2'b10) check("done_to_rsp", 128'(cyc), 128'(done_cyc + 1));
            end
         end
      end
   end

   initial begin
      int s0, g0;
      rst = 1'b1; req_valid = '0; xspi_ready = 1'b1;
      p_cmd[0] = 8'h12; p_addr[0] = 48'h0000_0000_1000; p_wdata[0] = 64'hDEADBEEF_00000001;
      p_cmd[1] = 8'hA7; p_addr[1] = 48'h1234_5678_9ABC; p_wdata[1] = 64'h0123_4567_89AB_CDEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 128'({busy, xspi_start, rsp_valid, rsp_id, rsp_status, rsp_attempts, req_ready}), 128'(0));
      check("reset_data", {xspi_command, xspi_address, xspi_wr_data}, 128'(0));
      check("reset_rdata", 128'(rsp_rdata), 128'(0));
      @(posedge clk); #1 rst = 1'b0;

      // single clean request, grant held off while the slave is not ready
      xspi_ready = 1'b0; req_valid = 2'b01;
      @(negedge clk);
      check("no_grant_not_ready", 128'(req_ready), 128'(0));
      @(posedge clk); #1 xspi_ready = 1'b1;
      push_exp(0, 2'b00, 1, rd_of(0, 1));
      wait_grant(1);
      req_valid = 2'b00;
      wait_rsp(1, 100);
      check("single_starts", 128'(n_start), 128'(1));

      // idle reset returns priority to requester 0, then alternate under contention
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      s0 = n_start; g0 = n_grant;
      push_exp(0, 2'b00, 1, rd_of(0, 1)); push_exp(1, 2'b00, 1, rd_of(1, 1));
      push_exp(0, 2'b00, 1, rd_of(0, 1)); push_exp(1, 2'b00, 1, rd_of(1, 1));
      req_valid = 2'b11;
      wait_grant(g0 + 4);
      req_valid = 2'b00;
      wait_rsp(5, 200);
      check("fair_starts", 128'(n_start - s0), 128'(4));
      for (int k = g0 + 1; k < g0 + 4; k++)
         check("no_repeat_grant", 128'(gnt_log[k] != gnt_log[k-1]), 128'(1));

      // single CRC error on attempt 1
      cfg_err = 4'b0010; cfg_err_atts = 1; s0 = n_start;
      push_exp(0, 2'b00, 2, rd_of(0, 2));
      req_valid = 2'b01;
      wait_grant(g0 + 5);
      req_valid = 2'b00;
      wait_rsp(6, 200);
      check("retry_starts", 128'(n_start - s0), 128'(2));

      // CRC error on every attempt; req0 waits pending meanwhile
      cfg_err = 4'b1000; cfg_err_atts = 15; s0 = n_start;
      push_exp(1, 2'b01, 4, rd_of(1, 4));
      req_valid = 2'b10;
      wait_grant(g0 + 6);
      req_valid = 2'b01; g0 = n_grant;
      wait_rsp(7, 300);
      check("crc_exhaust_starts", 128'(n_start - s0), 128'(4));
      check("no_grant_while_busy", 128'(gnt_at_rsp), 128'(g0));
      cfg_err_atts = 0;
      push_exp(0, 2'b00, 1, rd_of(0, 1));
      wait_grant(g0 + 1);
      req_valid = 2'b00;
      wait_rsp(8, 100);

      // done never arrives: timeout retries then status 10 with zero data
      cfg_never_done = 1'b1; s0 = n_start; g0 = n_grant;
      push_exp(1, 2'b10, 4, 64'h0);
      req_valid = 2'b10;
      wait_grant(g0 + 1);
      req_valid = 2'b00;
      wait_rsp(9, 400);
      check("tmo_starts", 128'(n_start - s0), 128'(4));
      cfg_never_done = 1'b0;

      // reset in WAIT abandons req0; pending req1 granted right after
      g0 = n_grant; s0 = n_start;
      req_valid = 2'b01;
      wait_grant(g0 + 1);
      req_valid = 2'b10;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      push_exp(1, 2'b00, 1, rd_of(1, 1));
      @(negedge clk);
      check("rst_busy_start", 128'({busy, xspi_start, rsp_valid}), 128'(0));
      check("rst_regrant", 128'(req_ready), 128'(2'b10));
      @(posedge clk); #1 req_valid = 2'b00;
      wait_rsp(10, 100);
      repeat (40) @(posedge clk);
      check("rsp_total", 128'(n_rsp), 128'(10));
      check("sb_drained", 128'(sb.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
